// File: rtl/synth_pkg.sv
// Shared constants and voice state encoding for the oscillator datapath.
// Imported by the phase accumulator and its adder.
package synth_pkg;

  localparam int PHASE_W = 16;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    RUN   = 2'd1,
    DRAIN = 2'd2
  } state_t;

endpackage

// File: rtl/phase_accumulator_adder.sv
// 16-bit ripple-carry adder feeding the oscillator phase register.
// Sum and carry out are purely combinational.
module SixteenBitFullAdder
  import synth_pkg::*;
(
  input  logic [PHASE_W-1:0] a,
  input  logic [PHASE_W-1:0] b,
  input  logic               c_in,
  output logic [PHASE_W-1:0] sum,
  output logic               c_out
);

  logic [PHASE_W:0] cy;

  always_comb begin
    cy    = '0;
    sum   = '0;
    cy[0] = c_in;
    for (int i = 0; i < PHASE_W; i++) begin
      sum[i]  = a[i] ^ b[i] ^ cy[i];
      cy[i+1] = (a[i] & b[i]) | (cy[i] & (a[i] ^ b[i]));
    end
    c_out = cy[PHASE_W];
  end

endmodule

// File: rtl/phase_accumulator.sv
// Gated oscillator phase accumulator with click-free note release.
// Define PHASE_HARD_SYNC_EN to add the hard_sync input.
module phase_accumulator
  import synth_pkg::*;
#(
  parameter int OUT_W = 8
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               sample_tick,
  input  logic [PHASE_W-1:0] freq_word,
  input  logic               freq_valid,
  output logic               freq_ready,
  input  logic               gate,
`ifdef PHASE_HARD_SYNC_EN
  input  logic               hard_sync,
`endif
  output logic [OUT_W-1:0]   phase_out,
  output logic               phase_valid,
  output logic               wrap
);

  logic [PHASE_W-1:0] phase;
  logic [PHASE_W-1:0] inc;
  logic [PHASE_W-1:0] pend;
  logic               pend_v;
  state_t             state;

  logic [PHASE_W-1:0] sum;
  logic               c_out;
  logic [PHASE_W-1:0] nxt_phase;
  logic               nxt_wrap;
  state_t             tick_state;
  state_t             nxt_state;
  logic               sync;

`ifdef PHASE_HARD_SYNC_EN
  assign sync = hard_sync;
`else
  assign sync = 1'b0;
`endif

  assign freq_ready = !pend_v;

  SixteenBitFullAdder u_add (
    .a     (phase),
    .b     (inc),
    .c_in  (1'b0),
    .sum   (sum),
    .c_out (c_out)
  );

  // Tick outcome under the current state first; gate moves apply after.
  always_comb begin
    nxt_phase  = phase;
    nxt_wrap   = 1'b0;
    tick_state = state;
    if (state == IDLE) nxt_phase = '0;
    if (sample_tick) begin
      unique case (state)
        IDLE: nxt_phase = '0;
        RUN: begin
          if (sync) begin
            nxt_phase = '0;
            nxt_wrap  = 1'b1;
          end else begin
            nxt_phase = sum;
            nxt_wrap  = c_out;
          end
        end
        DRAIN: begin
          if (sync || c_out) begin
            nxt_phase  = '0;
            nxt_wrap   = 1'b1;
            tick_state = IDLE;
          end else if (inc == '0) begin
            nxt_phase  = '0;
            tick_state = IDLE;
          end else begin
            nxt_phase = sum;
          end
        end
        default: begin
          nxt_phase  = '0;
          tick_state = IDLE;
        end
      endcase
    end
  end

  always_comb begin
    nxt_state = tick_state;
    unique case (tick_state)
      IDLE:    nxt_state = gate ? RUN : IDLE;
      RUN:     nxt_state = gate ? RUN : DRAIN;
      DRAIN:   nxt_state = gate ? RUN : DRAIN;
      default: nxt_state = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      phase       <= '0;
      inc         <= '0;
      pend        <= '0;
      pend_v      <= 1'b0;
      state       <= IDLE;
      phase_out   <= '0;
      phase_valid <= 1'b0;
      wrap        <= 1'b0;
    end else begin
      phase <= nxt_phase;
      state <= nxt_state;
      if (sample_tick) begin
        phase_out   <= nxt_phase[PHASE_W-1 -: OUT_W];
        phase_valid <= 1'b1;
        wrap        <= nxt_wrap;
        if (pend_v) begin
          inc    <= pend;
          pend_v <= 1'b0;
        end
      end else begin
        phase_valid <= 1'b0;
        wrap        <= 1'b0;
      end
      if (freq_valid && !pend_v) begin
        pend   <= freq_word;
        pend_v <= 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_phase_accumulator.sv
// Self-checking bench for phase_accumulator: directed scenarios plus
// randomized traffic against an arithmetic reference model.
module tb_phase_accumulator;

  localparam int OUT_W = 8;

  logic             clk = 1'b0;
  logic             reset;
  logic             sample_tick;
  logic [15:0]      freq_word;
  logic             freq_valid;
  logic             freq_ready;
  logic             gate;
  logic             hard_sync;
  logic [OUT_W-1:0] phase_out;
  logic             phase_valid;
  logic             wrap;

  int checks = 0;
  int errors = 0;

  // Reference model: mode 0 = silent, 1 = note held, 2 = releasing.
  int m_phase, m_inc, m_pend, m_mode;
  bit m_pv;
  int e_out;
  bit e_valid, e_wrap;

  phase_accumulator #(.OUT_W(OUT_W)) dut (
    .clk         (clk),
    .reset       (reset),
    .sample_tick (sample_tick),
    .freq_word   (freq_word),
    .freq_valid  (freq_valid),
    .freq_ready  (freq_ready),
    .gate        (gate),
`ifdef PHASE_HARD_SYNC_EN
    .hard_sync   (hard_sync),
`endif
    .phase_out   (phase_out),
    .phase_valid (phase_valid),
    .wrap        (wrap)
  );

  always #5 clk = ~clk;

  function automatic void model_reset();
    m_phase = 0;
    m_inc   = 0;
    m_pend  = 0;
    m_pv    = 0;
    m_mode  = 0;
    e_out   = 0;
    e_valid = 0;
    e_wrap  = 0;
  endfunction

  function automatic void model(input bit t, input bit g, input bit fv,
                                input int fw, input bit hs);
    bit acc;
    int s;
    acc = fv && !m_pv;
    if (t) begin
      e_valid = 1;
      e_wrap  = 0;
      if (m_mode == 0) begin
        m_phase = 0;
      end else if (hs) begin
        m_phase = 0;
        e_wrap  = 1;
        if (m_mode == 2) m_mode = 0;
      end else if (m_mode == 2 && m_inc == 0) begin
        m_phase = 0;
        m_mode  = 0;
      end else begin
        s       = m_phase + m_inc;
        e_wrap  = (s >= 65536);
        m_phase = s % 65536;
        if (m_mode == 2 && e_wrap) begin
          m_phase = 0;
          m_mode  = 0;
        end
      end
      e_out = m_phase >> (16 - OUT_W);
      if (m_pv) begin
        m_inc = m_pend;
        m_pv  = 0;
      end
    end else begin
      e_valid = 0;
      e_wrap  = 0;
    end
    if (acc) begin
      m_pend = fw;
      m_pv   = 1;
    end
    if (m_mode == 0 && g) m_mode = 1;
    else if (m_mode == 1 && !g) m_mode = 2;
    else if (m_mode == 2 && g) m_mode = 1;
  endfunction

  task automatic drive(input bit t, input bit g, input bit fv,
                       input logic [15:0] fw, input bit hs);
    sample_tick = t;
    gate        = g;
    freq_valid  = fv;
    freq_word   = fw;
    hard_sync   = hs;
`ifdef PHASE_HARD_SYNC_EN
    model(t, g, fv, int'(fw), hs);
`else
    model(t, g, fv, int'(fw), 1'b0);
`endif
    @(posedge clk);
    #1;
    sample_tick = 1'b0;
    freq_valid  = 1'b0;
    hard_sync   = 1'b0;
  endtask

  task automatic do_reset();
    reset       = 1'b1;
    sample_tick = 1'b0;
    freq_valid  = 1'b0;
    hard_sync   = 1'b0;
    gate        = 1'b0;
    model_reset();
    @(posedge clk);
    #1;
    reset = 1'b0;
  endtask

  task automatic test_reset();
    do_reset();
    checks++;
    if (phase_out !== '0) begin
      errors++;
      $display("FAIL reset_phase: got %0h want 0", phase_out);
    end
    checks++;
    if (phase_valid !== 1'b0 || wrap !== 1'b0) begin
      errors++;
      $display("FAIL reset_pulses: got v=%b w=%b want 0 0", phase_valid, wrap);
    end
    checks++;
    if (freq_ready !== 1'b1) begin
      errors++;
      $display("FAIL reset_ready: got %b want 1", freq_ready);
    end
  endtask

  task automatic test_run_wrap();
    logic [7:0] exp_o [5];
    logic       exp_w [5];
    exp_o = '{8'h40, 8'h80, 8'hC0, 8'h00, 8'h40};
    exp_w = '{1'b0, 1'b0, 1'b0, 1'b1, 1'b0};
    do_reset();
    drive(0, 1, 1, 16'h4000, 0);
    checks++;
    if (freq_ready !== 1'b0) begin
      errors++;
      $display("FAIL run_ready_low: got %b want 0", freq_ready);
    end
    drive(1, 1, 0, 16'h0, 0);
    checks++;
    if (phase_out !== 8'h00 || freq_ready !== 1'b1) begin
      errors++;
      $display("FAIL run_load_tick: got %0h r=%b want 0 r=1",
               phase_out, freq_ready);
    end
    for (int i = 0; i < 5; i++) begin
      drive(1, 1, 0, 16'h0, 0);
      checks++;
      if (phase_out !== exp_o[i] || wrap !== exp_w[i] ||
          phase_valid !== 1'b1) begin
        errors++;
        $display("FAIL run_tick%0d: got %0h w=%b v=%b want %0h w=%b v=1",
                 i, phase_out, wrap, phase_valid, exp_o[i], exp_w[i]);
      end
    end
    drive(0, 1, 0, 16'h0, 0);
    checks++;
    if (phase_valid !== 1'b0 || wrap !== 1'b0 || phase_out !== 8'h40) begin
      errors++;
      $display("FAIL run_idle_cycle: got %0h v=%b w=%b want 40 0 0",
               phase_out, phase_valid, wrap);
    end
  endtask

  task automatic test_drain();
    logic [7:0] exp_o [4];
    logic       exp_w [4];
    exp_o = '{8'hC0, 8'h00, 8'h00, 8'h00};
    exp_w = '{1'b0, 1'b1, 1'b0, 1'b0};
    drive(1, 1, 0, 16'h0, 0);
    checks++;
    if (phase_out !== 8'h80) begin
      errors++;
      $display("FAIL drain_pre: got %0h want 80", phase_out);
    end
    for (int i = 0; i < 4; i++) begin
      drive(1, 0, 0, 16'h0, 0);
      checks++;
      if (phase_out !== exp_o[i] || wrap !== exp_w[i]) begin
        errors++;
        $display("FAIL drain_tick%0d: got %0h w=%b want %0h w=%b",
                 i, phase_out, wrap, exp_o[i], exp_w[i]);
      end
    end
  endtask

  task automatic test_freq_change();
    logic [7:0] exp_o [3];
    exp_o = '{8'h30, 8'h50, 8'h70};
    do_reset();
    drive(0, 1, 1, 16'h1000, 0);
    drive(1, 1, 0, 16'h0, 0);
    drive(1, 1, 0, 16'h0, 0);
    drive(1, 1, 0, 16'h0, 0);
    checks++;
    if (phase_out !== 8'h20) begin
      errors++;
      $display("FAIL freq_base: got %0h want 20", phase_out);
    end
    drive(0, 1, 1, 16'h2000, 0);
    checks++;
    if (freq_ready !== 1'b0) begin
      errors++;
      $display("FAIL freq_ready_drop: got %b want 0", freq_ready);
    end
    drive(0, 1, 1, 16'h7000, 0);
    checks++;
    if (freq_ready !== 1'b0) begin
      errors++;
      $display("FAIL freq_second_offer: got %b want 0", freq_ready);
    end
    for (int i = 0; i < 3; i++) begin
      drive(1, 1, 0, 16'h0, 0);
      checks++;
      if (phase_out !== exp_o[i] || freq_ready !== 1'b1) begin
        errors++;
        $display("FAIL freq_tick%0d: got %0h r=%b want %0h r=1",
                 i, phase_out, freq_ready, exp_o[i]);
      end
    end
  endtask

  task automatic test_drain_zero_inc();
    logic [7:0] exp_o [4];
    logic       exp_w [4];
    do_reset();
    drive(0, 1, 0, 16'h0, 0);
    drive(0, 0, 0, 16'h0, 0);
    drive(1, 0, 1, 16'h4000, 0);
    checks++;
    if (phase_out !== 8'h00 || wrap !== 1'b0 || phase_valid !== 1'b1) begin
      errors++;
      $display("FAIL zinc_drain_tick: got %0h w=%b v=%b want 0 0 1",
               phase_out, wrap, phase_valid);
    end
    drive(1, 0, 0, 16'h0, 0);
    drive(1, 0, 0, 16'h0, 0);
    checks++;
    if (phase_out !== 8'h00) begin
      errors++;
      $display("FAIL zinc_idle_hold: got %0h want 0", phase_out);
    end
    exp_o = '{8'h80, 8'hC0, 8'h00, 8'h40};
    exp_w = '{1'b0, 1'b0, 1'b1, 1'b0};
    drive(1, 1, 0, 16'h0, 0);
    drive(1, 1, 0, 16'h0, 0);
    drive(0, 0, 0, 16'h0, 0);
    drive(0, 1, 0, 16'h0, 0);
    for (int i = 0; i < 4; i++) begin
      drive(1, 1, 0, 16'h0, 0);
      checks++;
      if (phase_out !== exp_o[i] || wrap !== exp_w[i]) begin
        errors++;
        $display("FAIL regate_tick%0d: got %0h w=%b want %0h w=%b",
                 i, phase_out, wrap, exp_o[i], exp_w[i]);
      end
    end
  endtask

  task automatic test_reset_mid();
    do_reset();
    drive(0, 1, 1, 16'h4000, 0);
    for (int i = 0; i < 4; i++) drive(1, 1, 0, 16'h0, 0);
    checks++;
    if (phase_out !== 8'hC0) begin
      errors++;
      $display("FAIL mid_pre: got %0h want C0", phase_out);
    end
    drive(0, 1, 1, 16'h1234, 0);
    do_reset();
    checks++;
    if (phase_out !== '0 || freq_ready !== 1'b1 || phase_valid !== 1'b0) begin
      errors++;
      $display("FAIL mid_reset: got %0h r=%b v=%b want 0 1 0",
               phase_out, freq_ready, phase_valid);
    end
    drive(1, 0, 0, 16'h0, 0);
    checks++;
    if (phase_out !== '0 || wrap !== 1'b0 || freq_ready !== 1'b1) begin
      errors++;
      $display("FAIL mid_after: got %0h w=%b r=%b want 0 0 1",
               phase_out, wrap, freq_ready);
    end
  endtask

`ifdef PHASE_HARD_SYNC_EN
  task automatic test_hard_sync();
    do_reset();
    drive(0, 1, 1, 16'h4000, 0);
    for (int i = 0; i < 3; i++) drive(1, 1, 0, 16'h0, 0);
    drive(1, 1, 0, 16'h0, 1);
    checks++;
    if (phase_out !== 8'h00 || wrap !== 1'b1) begin
      errors++;
      $display("FAIL sync_tick: got %0h w=%b want 0 w=1", phase_out, wrap);
    end
    drive(1, 1, 0, 16'h0, 0);
    checks++;
    if (phase_out !== 8'h40 || wrap !== 1'b0) begin
      errors++;
      $display("FAIL sync_after: got %0h w=%b want 40 w=0", phase_out, wrap);
    end
  endtask
`endif

  task automatic test_random();
    bit g;
    g = 1'b0;
    do_reset();
    for (int n = 0; n < 600; n++) begin
      if ($urandom_range(0, 99) == 0) begin
        do_reset();
        g = 1'b0;
      end else begin
        if ($urandom_range(0, 9) == 0) g = !g;
        drive($urandom_range(0, 1) == 1, g, $urandom_range(0, 2) == 0,
              16'($urandom), $urandom_range(0, 9) == 0);
      end
      checks++;
      if (phase_out !== OUT_W'(e_out) || phase_valid !== e_valid ||
          wrap !== e_wrap || freq_ready !== !m_pv) begin
        errors++;
        $display("FAIL rand%0d: got %0h v=%b w=%b r=%b want %0h v=%b w=%b r=%b",
                 n, phase_out, phase_valid, wrap, freq_ready,
                 e_out, e_valid, e_wrap, !m_pv);
      end
    end
  endtask

  initial begin
    reset       = 1'b1;
    sample_tick = 1'b0;
    freq_word   = '0;
    freq_valid  = 1'b0;
    gate        = 1'b0;
    hard_sync   = 1'b0;
    model_reset();
    test_reset();
    test_run_wrap();
    test_drain();
    test_freq_change();
    test_drain_zero_inc();
    test_reset_mid();
`ifdef PHASE_HARD_SYNC_EN
    test_hard_sync();
`endif
    test_random();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
